// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//    Unsigned WIDTH x WIDTH multiplier. It computes the product by iterative
//    shift-and-add and reuses one ripple-carry adder built from chained fa
//    cells. It runs one add/shift step per clock and gives a 2*WIDTH-bit
//    product together with a one-cycle done pulse.
//
// Ports
//    CLOCK_50 : system clock, rising-edge active
//    resetn   : asynchronous active-low reset
//    start    : begin a multiply (level-sampled, acted on only when idle)
//    a, b     : multiplicand / multiplier, sampled on the accepting edge
//    busy     : high while the add/shift sequence runs
//    done     : one-cycle pulse, product valid
//    product  : result register, holds until the next completion

// fa
//    One-bit full adder cell.
// Ports
//    x, y : addend bits
//    ci   : carry in
//    s    : sum
//    co   : carry out
module fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module shift_add_mult_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] m, acc, q;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] addend, sum;
   logic [WIDTH:0]   carry;
   logic             cout;
   logic             last;

   // Shared ripple-carry adder: ACC + (Q[0] ? M : 0), carry in tied low
   assign addend   = q[0] ? m : '0;
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      fa u_fa (
         .x  (acc[i]),
         .y  (addend[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];
   assign last = (count == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decode straight from the state register, so they are glitch-free
   // and busy/done are mutually exclusive by construction
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: {ACC, Q} shifts right one place per step. The adder carry-out
   // enters ACC at the top, so the full 2*WIDTH-bit product never overflows.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         m       <= '0;
         acc     <= '0;
         q       <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  m     <= a;
                  q     <= b;
                  acc   <= '0;
                  count <= '0;
               end
            end
            RUN: begin
               acc   <= {cout, sum[WIDTH-1:1]};
               q     <= {sum[0], q[WIDTH-1:1]};
               count <= count + 1'b1;
               if (last) product <= {cout, sum[WIDTH-1:1], sum[0], q[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end

endmodule
